// File: rtl/wm8978_i2s_rx_pkg.sv
// Shared definitions for the WM8978 I2S ADC receiver.
//   i2s_rx_state_t : receiver FSM states
//   CH_LEFT/RIGHT  : lrck level that identifies each channel slot
//   BCLK_DIV_MIN   : minimum clk_120m cycles per codec bit clock period
package wm8978_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } i2s_rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int BCLK_DIV_MIN = 8;

endpackage

// File: rtl/wm8978_i2s_rx_if.sv
// Bundle of codec pins and receiver results.
//   i2s_bclk/i2s_lrck/i2s_adcdat : codec serial pins (into the receiver)
//   left_data/right_data         : last complete sample pair
//   sample_valid                 : 1-cycle pulse, pair updated
//   frame_err                    : 1-cycle pulse, short slot seen
// master = receiver side, slave = codec pins driver / sample consumer.
interface wm8978_i2s_rx_if #(
  parameter int DATA_W = 16
);
  logic              i2s_bclk;
  logic              i2s_lrck;
  logic              i2s_adcdat;
  logic [DATA_W-1:0] left_data;
  logic [DATA_W-1:0] right_data;
  logic              sample_valid;
  logic              frame_err;

  modport master (
    input  i2s_bclk, i2s_lrck, i2s_adcdat,
    output left_data, right_data, sample_valid, frame_err
  );

  modport slave (
    output i2s_bclk, i2s_lrck, i2s_adcdat,
    input  left_data, right_data, sample_valid, frame_err
  );
endinterface

// File: rtl/wm8978_i2s_rx_sync_edge.sv
// Synchronizes the asynchronous codec pins into clk_120m and detects the
// bit clock rising edge.
//   clk_120m, s_rst                : system clock, sync active-high reset
//   i2s_bclk, i2s_lrck, i2s_adcdat : raw codec pins
//   bclk_rise                      : 1-cycle pulse per bclk rising edge
//   lrck_s, dat_s                  : lrck/data aligned with bclk_rise
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_120m,
  input  logic s_rst,
  input  logic i2s_bclk,
  input  logic i2s_lrck,
  input  logic i2s_adcdat,
  output logic bclk_rise,
  output logic lrck_s,
  output logic dat_s
);

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_prev;

  always_ff @(posedge clk_120m) begin
    if (s_rst) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
      bclk_rise <= 1'b0;
      lrck_s    <= 1'b0;
      dat_s     <= 1'b0;
    end else begin
      // synchronizer chains
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], i2s_adcdat};
      // edge-detect stage: lrck/dat registered alongside so all three line up
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
      bclk_rise <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
      lrck_s    <= lrck_sync[SYNC_STAGES-1];
      dat_s     <= dat_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/wm8978_i2s_rx.sv
// WM8978 ADC receiver, I2S Philips format, codec is clock master.
//   clk_120m, s_rst : system clock, synchronous active-high reset
//   bus (master)    : codec pins in; left_data/right_data, sample_valid,
//                     frame_err out
// Pairs are always left-then-right; a right slot is only captured when a
// complete left sample is held, so outputs never mix samples of two frames.
module wm8978_i2s_rx
  import wm8978_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_120m,
  input  logic            s_rst,
  wm8978_i2s_rx_if.master bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic bclk_rise;
  logic lrck_s;
  logic dat_s;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_120m   (clk_120m),
    .s_rst      (s_rst),
    .i2s_bclk   (bus.i2s_bclk),
    .i2s_lrck   (bus.i2s_lrck),
    .i2s_adcdat (bus.i2s_adcdat),
    .bclk_rise  (bclk_rise),
    .lrck_s     (lrck_s),
    .dat_s      (dat_s)
  );

  i2s_rx_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              ch_q, ch_d;
  logic              lrck_prev_q, lrck_prev_d;
  logic              lhv_q, lhv_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_next;
  logic [DATA_W-1:0] lh_q, lh_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              sv_q, sv_d;
  logic              fe_q, fe_d;
  logic              slot_start;

  assign slot_start = bclk_rise && (lrck_s != lrck_prev_q);
  assign cnt_inc    = cnt_q + 1'b1;
  assign sh_next    = {sh_q[DATA_W-2:0], dat_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    lrck_prev_d = lrck_prev_q;
    lhv_d       = lhv_q;
    sh_d        = sh_q;
    lh_d        = lh_q;
    ld_d        = ld_q;
    rd_d        = rd_q;
    sv_d        = 1'b0;
    fe_d        = 1'b0;
    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
      unique case (state_q)
        IDLE: begin
          if (slot_start && lrck_s == CH_LEFT) begin
            state_d = SHIFT;
            cnt_d   = '0;
            ch_d    = CH_LEFT;
          end
        end
        SHIFT: begin
          if (slot_start) begin
            // short slot: drop the pair, then treat this edge as IDLE would
            fe_d  = 1'b1;
            lhv_d = 1'b0;
            cnt_d = '0;
            ch_d  = CH_LEFT;
            state_d = (lrck_s == CH_LEFT) ? SHIFT : IDLE;
          end else begin
            sh_d  = sh_next;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DATA_W)) begin
              state_d = HOLD;
              if (ch_q == CH_LEFT) begin
                lh_d  = sh_next;
                lhv_d = 1'b1;
              end else begin
                ld_d  = lh_q;
                rd_d  = sh_next;
                sv_d  = 1'b1;
                lhv_d = 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (slot_start) begin
            cnt_d = '0;
            if (lrck_s == CH_RIGHT && lhv_q) begin
              state_d = SHIFT;
              ch_d    = CH_RIGHT;
            end else if (lrck_s == CH_LEFT) begin
              state_d = SHIFT;
              ch_d    = CH_LEFT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_120m) begin
    if (s_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ch_q        <= CH_LEFT;
      lrck_prev_q <= 1'b0;
      lhv_q       <= 1'b0;
      sh_q        <= '0;
      lh_q        <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      sv_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      lrck_prev_q <= lrck_prev_d;
      lhv_q       <= lhv_d;
      sh_q        <= sh_d;
      lh_q        <= lh_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      sv_q        <= sv_d;
      fe_q        <= fe_d;
    end
  end

  assign bus.left_data    = ld_q;
  assign bus.right_data   = rd_q;
  assign bus.sample_valid = sv_q;
  assign bus.frame_err    = fe_q;

endmodule

// File: tb/tb_wm8978_i2s_rx.sv
// Directed bench for wm8978_i2s_rx: a 16-bit and a 24-bit receiver share the
// same codec pin stimulus; each test checks only the instance it targets.
module tb_wm8978_i2s_rx;
  import wm8978_pkg::*;

  localparam int CLK_PERIOD = 8;
  localparam int BCLK_HALF  = (BCLK_DIV_MIN / 2) * CLK_PERIOD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b0;
  logic lrck = 1'b0;
  logic dat = 1'b0;

  int checks = 0;
  int errors = 0;

  wm8978_i2s_rx_if #(.DATA_W(16)) if16 ();
  wm8978_i2s_rx_if #(.DATA_W(24)) if24 ();

  assign if16.i2s_bclk = bclk;
  assign if16.i2s_lrck = lrck;
  assign if16.i2s_adcdat = dat;
  assign if24.i2s_bclk = bclk;
  assign if24.i2s_lrck = lrck;
  assign if24.i2s_adcdat = dat;

  wm8978_i2s_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .clk_120m (clk),
    .s_rst    (rst),
    .bus      (if16)
  );

  wm8978_i2s_rx #(.DATA_W(24), .SYNC_STAGES(2)) dut24 (
    .clk_120m (clk),
    .s_rst    (rst),
    .bus      (if24)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  logic [15:0] q16l[$], q16r[$];
  logic [23:0] q24l[$], q24r[$];
  int fe16 = 0, fe24 = 0, both16 = 0, both24 = 0;

  always @(negedge clk) begin
    if (if16.sample_valid) begin
      q16l.push_back(if16.left_data);
      q16r.push_back(if16.right_data);
    end
    if (if24.sample_valid) begin
      q24l.push_back(if24.left_data);
      q24r.push_back(if24.right_data);
    end
    if (if16.frame_err) fe16++;
    if (if24.frame_err) fe24++;
    if (if16.sample_valid && if16.frame_err) both16++;
    if (if24.sample_valid && if24.frame_err) both24++;
  end

  // One lrck half-period of len bit clocks. The first rise carries the
  // previous slot's last bit; the next w rises carry word MSB first.
  task automatic send_slot(input logic lr, input logic [31:0] word,
                           input int w, input int len);
    for (int k = 0; k < len; k++) begin
      bclk = 1'b0;
      lrck = lr;
      if (k >= 1) begin
        if (k <= w) dat = word[w-k];
        else        dat = 1'b0;
      end
      #(BCLK_HALF);
      bclk = 1'b1;
      #(BCLK_HALF);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int w, input int len);
    send_slot(1'b0, l, w, len);
    send_slot(1'b1, r, w, len);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(5);
    @(negedge clk);
    checks++; if (if16.left_data !== 16'h0) begin errors++; $display("FAIL reset_left16 got %h want 0000", if16.left_data); end
    checks++; if (if16.right_data !== 16'h0) begin errors++; $display("FAIL reset_right16 got %h want 0000", if16.right_data); end
    checks++; if (if16.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid16 got %b want 0", if16.sample_valid); end
    checks++; if (if16.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr16 got %b want 0", if16.frame_err); end
    checks++; if (if24.right_data !== 24'h0) begin errors++; $display("FAIL reset_right24 got %h want 000000", if24.right_data); end
    @(posedge clk); #1 rst = 1'b0;
    idle(4);
  endtask

  task automatic test_basic16();
    int v0, f0;
    v0 = q16l.size(); f0 = fe16;
    send_frame(32'h0, 32'h0, 16, 32);      // lost while aligning to a left slot
    for (int i = 0; i < 4; i++) send_frame(32'hA55A, 32'h1234, 16, 32);
    idle(12);
    checks++; if (q16l.size() - v0 !== 4) begin errors++; $display("FAIL basic_count got %0d want 4", q16l.size() - v0); end
    for (int i = 0; i < 4; i++) begin
      if (v0 + i < q16l.size()) begin
        checks++; if (q16l[v0+i] !== 16'hA55A) begin errors++; $display("FAIL basic_left[%0d] got %h want a55a", i, q16l[v0+i]); end
        checks++; if (q16r[v0+i] !== 16'h1234) begin errors++; $display("FAIL basic_right[%0d] got %h want 1234", i, q16r[v0+i]); end
      end
    end
    checks++; if (fe16 - f0 !== 0) begin errors++; $display("FAIL basic_ferr got %0d want 0", fe16 - f0); end
  endtask

  task automatic test_exact24();
    int v0, f0;
    v0 = q24l.size(); f0 = fe24;
    for (int i = 0; i < 3; i++) send_frame(32'h800001, 32'h7FFFFE, 24, 25);
    idle(12);
    checks++; if (q24l.size() - v0 !== 3) begin errors++; $display("FAIL exact_count got %0d want 3", q24l.size() - v0); end
    for (int i = 0; i < 3; i++) begin
      if (v0 + i < q24l.size()) begin
        checks++; if (q24l[v0+i] !== 24'h800001) begin errors++; $display("FAIL exact_left[%0d] got %h want 800001", i, q24l[v0+i]); end
        checks++; if (q24r[v0+i] !== 24'h7FFFFE) begin errors++; $display("FAIL exact_right[%0d] got %h want 7ffffe", i, q24r[v0+i]); end
      end
    end
    checks++; if (fe24 - f0 !== 0) begin errors++; $display("FAIL exact_ferr got %0d want 0", fe24 - f0); end
  endtask

  task automatic test_short_slot();
    int v0, f0;
    v0 = q16l.size(); f0 = fe16;
    send_slot(1'b0, 32'hFFFF, 16, 9);
    send_slot(1'b1, 32'hBEEF, 16, 32);
    send_frame(32'h0F0F, 32'hF0F0, 16, 32);
    idle(12);
    checks++; if (fe16 - f0 !== 1) begin errors++; $display("FAIL short_ferr got %0d want 1", fe16 - f0); end
    checks++; if (q16l.size() - v0 !== 1) begin errors++; $display("FAIL short_count got %0d want 1", q16l.size() - v0); end
    if (v0 < q16l.size()) begin
      checks++; if (q16l[v0] !== 16'h0F0F) begin errors++; $display("FAIL short_left got %h want 0f0f", q16l[v0]); end
      checks++; if (q16r[v0] !== 16'hF0F0) begin errors++; $display("FAIL short_right got %h want f0f0", q16r[v0]); end
    end
  endtask

  task automatic test_reset_mid_right();
    int v0;
    v0 = q16l.size();
    rst = 1'b1;
    fork
      send_frame(32'hDEAD, 32'hC0DE, 16, 32);
      begin
        #(32 * 2 * BCLK_HALF + 10 * 2 * BCLK_HALF);
        @(negedge clk);
        checks++; if (if16.left_data !== 16'h0) begin errors++; $display("FAIL rstr_left got %h want 0000", if16.left_data); end
        checks++; if (if16.right_data !== 16'h0) begin errors++; $display("FAIL rstr_right got %h want 0000", if16.right_data); end
        @(posedge clk); #1 rst = 1'b0;
      end
    join
    send_frame(32'h3C3C, 32'hC3C3, 16, 32);
    idle(12);
    checks++; if (q16l.size() - v0 !== 1) begin errors++; $display("FAIL rstr_count got %0d want 1", q16l.size() - v0); end
    if (v0 < q16l.size()) begin
      checks++; if (q16l[v0] !== 16'h3C3C) begin errors++; $display("FAIL rstr_left_out got %h want 3c3c", q16l[v0]); end
      checks++; if (q16r[v0] !== 16'hC3C3) begin errors++; $display("FAIL rstr_right_out got %h want c3c3", q16r[v0]); end
    end
  endtask

  task automatic test_reset_pulse();
    int v0;
    v0 = q16l.size();
    fork
      begin
        send_frame(32'h7777, 32'h8888, 16, 32);
        send_frame(32'h0123, 32'hFEDC, 16, 32);
      end
      begin
        #(10 * 2 * BCLK_HALF);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (if16.left_data !== 16'h0) begin errors++; $display("FAIL rstp_left got %h want 0000", if16.left_data); end
        checks++; if (if16.right_data !== 16'h0) begin errors++; $display("FAIL rstp_right got %h want 0000", if16.right_data); end
        checks++; if (if16.sample_valid !== 1'b0) begin errors++; $display("FAIL rstp_valid got %b want 0", if16.sample_valid); end
      end
    join
    idle(12);
    checks++; if (q16l.size() - v0 !== 1) begin errors++; $display("FAIL rstp_count got %0d want 1", q16l.size() - v0); end
    if (v0 < q16l.size()) begin
      checks++; if (q16l[v0] !== 16'h0123) begin errors++; $display("FAIL rstp_left_out got %h want 0123", q16l[v0]); end
      checks++; if (q16r[v0] !== 16'hFEDC) begin errors++; $display("FAIL rstp_right_out got %h want fedc", q16r[v0]); end
    end
  endtask

  task automatic test_random();
    int v0, f0, len;
    logic [15:0] el[$], er[$];
    logic [15:0] l, r;
    v0 = q16l.size(); f0 = fe16;
    for (int i = 0; i < 100; i++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      len = $urandom_range(17, 24);
      el.push_back(l);
      er.push_back(r);
      #($urandom_range(0, 7));
      send_frame({16'h0, l}, {16'h0, r}, 16, len);
    end
    idle(12);
    checks++; if (q16l.size() - v0 !== 100) begin errors++; $display("FAIL rand_count got %0d want 100", q16l.size() - v0); end
    for (int i = 0; i < 100; i++) begin
      if (v0 + i < q16l.size()) begin
        checks++; if (q16l[v0+i] !== el[i]) begin errors++; $display("FAIL rand_left[%0d] got %h want %h", i, q16l[v0+i], el[i]); end
        checks++; if (q16r[v0+i] !== er[i]) begin errors++; $display("FAIL rand_right[%0d] got %h want %h", i, q16r[v0+i], er[i]); end
      end
    end
    checks++; if (fe16 - f0 !== 0) begin errors++; $display("FAIL rand_ferr got %0d want 0", fe16 - f0); end
  endtask

  task automatic test_exclusive();
    checks++; if (both16 !== 0) begin errors++; $display("FAIL excl16 got %0d want 0", both16); end
    checks++; if (both24 !== 0) begin errors++; $display("FAIL excl24 got %0d want 0", both24); end
  endtask

  initial begin
    test_reset();
    test_basic16();
    test_exact24();
    test_short_slot();
    test_reset_mid_right();
    test_reset_pulse();
    test_random();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
